// File: rtl/gf2_poly_div_16_if.sv
// Handshake bundle for the GF(2) polynomial divider.
// The master side supplies operands and accepts results.
// The slave side is the divider itself.
interface gf2_poly_div_16_if #(
  parameter int M = 16,
  parameter int N = 31
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [M-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] q;
  logic [M-2:0] r;
  logic         div_by_zero;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, q, r, div_by_zero
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, q, r, div_by_zero
  );
endinterface

// File: rtl/gf2_poly_div_16.sv
// Sequential GF(2) polynomial divider: bit-serial long division of an N-bit
// dividend by an M-bit divisor. It produces the quotient and the remainder.
// Optional macro GF2DIV_UNROLL2_EN: when it is defined, the divider retires
// two dividend bits per RUN cycle. The results are identical in both modes.
module gf2_poly_div_16 #(
  parameter int M = 16,
  parameter int N = 31
) (
  input logic              clk,
  input logic              rst,
  gf2_poly_div_16_if.slave bus
);

  localparam int DW = $clog2(M);
  localparam int CW = $clog2(N);
`ifdef GF2DIV_UNROLL2_EN
  localparam int STEPS = 2;
`else
  localparam int STEPS = 1;
`endif

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_reg, state_next;
  logic [N-1:0]    a_reg;
  logic [M-1:0]    b_reg;
  logic [DW-1:0]   d_reg;
  logic [CW-1:0]   cnt_reg;
  logic [M-2:0]    rem_reg;
  logic [N-1:0]    quo_reg;
  logic            zero_reg;
  logic [N-1:0]    q_reg;
  logic [M-2:0]    r_reg;
  logic            dbz_reg;

  logic            in_ready_c;
  logic            out_valid_c;
  logic            accept;
  logic            last_step;
  logic [M-1:0]    s1;
  logic [M-2:0]    rem_step;
  logic [N-1:0]    quo_step;
`ifdef GF2DIV_UNROLL2_EN
  logic [M-1:0]    s2;
  logic [CW-1:0]   cnt_m1;
`endif

  // Index of the leading coefficient of the divisor (0 when b is zero).
  function automatic logic [DW-1:0] msb_index(input logic [M-1:0] bv);
    logic [DW-1:0] idx;
    idx = '0;
    for (int i = 0; i < M; i++) begin
      if (bv[i]) idx = DW'(i);
    end
    return idx;
  endfunction

  // One long-division step. The function shifts in a dividend bit and
  // subtracts the divisor when the leading term lines up.
  // It returns {quotient bit, new remainder}.
  // Bit M-1 of the shifted value is always cleared again, so it is dropped.
  function automatic logic [M-1:0] div_step(input logic [M-2:0] rin,
                                            input logic          abit,
                                            input logic [M-1:0]  bv,
                                            input logic [DW-1:0] d);
    logic [M-1:0] t;
    logic         qb;
    t  = {rin, abit};
    qb = t[d];
    if (qb) t = t ^ bv;
    return {qb, t[M-2:0]};
  endfunction

  assign accept = bus.in_valid & in_ready_c;

`ifdef GF2DIV_UNROLL2_EN
  assign last_step = (cnt_reg <= CW'(1));
`else
  assign last_step = (cnt_reg == '0);
`endif

  // Next quotient/remainder after this cycle's division step(s).
  always_comb begin
    s1       = div_step(rem_reg, a_reg[cnt_reg], b_reg, d_reg);
    rem_step = s1[M-2:0];
    quo_step = quo_reg;
    quo_step[cnt_reg] = s1[M-1];
`ifdef GF2DIV_UNROLL2_EN
    cnt_m1 = cnt_reg - CW'(1);
    s2     = div_step(s1[M-2:0], a_reg[cnt_m1], b_reg, d_reg);
    // When N is odd, the last cycle has only bit 0 left to process.
    if (cnt_reg != '0) begin
      rem_step         = s2[M-2:0];
      quo_step[cnt_m1] = s2[M-1];
    end
`endif
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = RUN;
      RUN:     if (last_step) state_next = DONE;
      DONE:    if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs, decoded from the state register.
  always_comb begin
    in_ready_c  = (state_reg == IDLE);
    out_valid_c = (state_reg == DONE);
  end

  // Operand capture, iteration, and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg    <= '0;
      b_reg    <= '0;
      d_reg    <= '0;
      cnt_reg  <= '0;
      rem_reg  <= '0;
      quo_reg  <= '0;
      zero_reg <= 1'b0;
      q_reg    <= '0;
      r_reg    <= '0;
      dbz_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            a_reg    <= bus.a;
            b_reg    <= bus.b;
            d_reg    <= msb_index(bus.b);
            rem_reg  <= '0;
            quo_reg  <= '0;
            zero_reg <= (bus.b == '0);
            // A zero divisor makes one pass through RUN. This gives the
            // zero-divisor result a latency of one edge.
            cnt_reg  <= (bus.b == '0) ? '0 : CW'(N - 1);
          end
        end
        RUN: begin
          rem_reg <= rem_step;
          quo_reg <= quo_step;
          cnt_reg <= cnt_reg - CW'(STEPS);
          if (last_step) begin
            q_reg   <= zero_reg ? '0 : quo_step;
            r_reg   <= zero_reg ? '0 : rem_step;
            dbz_reg <= zero_reg;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready    = in_ready_c;
  assign bus.out_valid   = out_valid_c;
  assign bus.q           = q_reg;
  assign bus.r           = r_reg;
  assign bus.div_by_zero = dbz_reg;

endmodule

// File: tb/tb_gf2_poly_div_16.sv
// Directed and randomised checks for gf2_poly_div_16.
// Inputs are driven on the falling edge, and outputs are sampled on the falling edge.
module tb_gf2_poly_div_16;

`ifdef GF2DIV_UNROLL2_EN
  localparam int LAT = 16;
`else
  localparam int LAT = 31;
`endif

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  gf2_poly_div_16_if #(.M(16), .N(31)) dut_if ();

  gf2_poly_div_16 #(.M(16), .N(31)) dut (
    .clk (clk),
    .rst (rst),
    .bus (dut_if)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] clmul(input logic [30:0] x, input logic [15:0] y);
    logic [63:0] p;
    p = '0;
    for (int i = 0; i < 31; i++) begin
      if (x[i]) p = p ^ ({48'b0, y} << i);
    end
    return p;
  endfunction

  function automatic int deg(input logic [63:0] v);
    int d;
    d = -1;
    for (int i = 0; i < 64; i++) begin
      if (v[i]) d = i;
    end
    return d;
  endfunction

  // Present one operation. The task returns at the falling edge just after the accepting edge.
  task automatic start_op(input logic [30:0] av, input logic [15:0] bv);
    int guard;
    guard = 0;
    @(negedge clk);
    while (dut_if.in_ready !== 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    total++;
    if (dut_if.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL start_op_ready: in_ready=%b want 1", dut_if.in_ready);
    end
    dut_if.a        = av;
    dut_if.b        = bv;
    dut_if.in_valid = 1'b1;
    @(negedge clk);
    dut_if.in_valid = 1'b0;
    dut_if.a        = 31'h2A5A_5A5A;
    dut_if.b        = 16'hFFFF;
  endtask

  // Count the edges after acceptance until out_valid is seen. The wait is bounded.
  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (dut_if.out_valid !== 1'b1 && lat < 100);
  endtask

  task automatic ack();
    dut_if.out_ready = 1'b1;
    @(negedge clk);
    dut_if.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    dut_if.in_valid  = 1'b0;
    dut_if.out_ready = 1'b0;
    dut_if.a         = '0;
    dut_if.b         = '0;
    repeat (3) @(negedge clk);
    total += 5;
    if (dut_if.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", dut_if.in_ready); end
    if (dut_if.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", dut_if.out_valid); end
    if (dut_if.q !== 31'h0) begin bad++; $display("FAIL reset_q: got %h want 0", dut_if.q); end
    if (dut_if.r !== 15'h0) begin bad++; $display("FAIL reset_r: got %h want 0", dut_if.r); end
    if (dut_if.div_by_zero !== 1'b0) begin bad++; $display("FAIL reset_dbz: got %b want 0", dut_if.div_by_zero); end
    rst = 1'b0;
    $display("reset: in_ready=%b out_valid=%b", dut_if.in_ready, dut_if.out_valid);
  endtask

  task automatic test_directed();
    logic [30:0] va [6] = '{31'h5, 31'h7, 31'h7FFF_FFFF, 31'h1234_5678, 31'h10, 31'h100};
    logic [15:0] vb [6] = '{16'h3, 16'h3, 16'h8000, 16'h1, 16'h3, 16'h11B};
    logic [30:0] eq [6] = '{31'h3, 31'h2, 31'h0000_FFFF, 31'h1234_5678, 31'hF, 31'h1};
    logic [14:0] er [6] = '{15'h0, 15'h1, 15'h7FFF, 15'h0, 15'h1, 15'h1B};
    int lat;
    for (int k = 0; k < 6; k++) begin
      start_op(va[k], vb[k]);
      wait_valid(lat);
      total += 4;
      if (lat != LAT) begin bad++; $display("FAIL directed_lat[%0d]: got %0d want %0d", k, lat, LAT); end
      if (dut_if.q !== eq[k]) begin bad++; $display("FAIL directed_q[%0d]: got %h want %h", k, dut_if.q, eq[k]); end
      if (dut_if.r !== er[k]) begin bad++; $display("FAIL directed_r[%0d]: got %h want %h", k, dut_if.r, er[k]); end
      if (dut_if.div_by_zero !== 1'b0) begin bad++; $display("FAIL directed_dbz[%0d]: got %b want 0", k, dut_if.div_by_zero); end
      $display("op a=%h b=%h -> q=%h r=%h lat=%0d", va[k], vb[k], dut_if.q, dut_if.r, lat);
      ack();
    end
  endtask

  task automatic test_div_by_zero();
    int lat;
    start_op(31'h1234_5678, 16'h0000);
    wait_valid(lat);
    total += 4;
    if (lat != 1) begin bad++; $display("FAIL dbz_lat: got %0d want 1", lat); end
    if (dut_if.div_by_zero !== 1'b1) begin bad++; $display("FAIL dbz_flag: got %b want 1", dut_if.div_by_zero); end
    if (dut_if.q !== 31'h0) begin bad++; $display("FAIL dbz_q: got %h want 0", dut_if.q); end
    if (dut_if.r !== 15'h0) begin bad++; $display("FAIL dbz_r: got %h want 0", dut_if.r); end
    $display("op a=12345678 b=0000 -> dbz=%b lat=%0d", dut_if.div_by_zero, lat);
    ack();
    start_op(31'h5, 16'h3);
    wait_valid(lat);
    total += 2;
    if (dut_if.div_by_zero !== 1'b0) begin bad++; $display("FAIL dbz_clear: got %b want 0", dut_if.div_by_zero); end
    if (dut_if.q !== 31'h3) begin bad++; $display("FAIL dbz_next_q: got %h want 3", dut_if.q); end
    $display("op a=5 b=3 after dbz -> q=%h dbz=%b", dut_if.q, dut_if.div_by_zero);
    ack();
  endtask

  task automatic test_back_pressure();
    int lat;
    start_op(31'h10, 16'h3);
    wait_valid(lat);
    for (int k = 0; k < 5; k++) begin
      total += 4;
      if (dut_if.out_valid !== 1'b1) begin bad++; $display("FAIL bp_out_valid[%0d]: got %b want 1", k, dut_if.out_valid); end
      if (dut_if.q !== 31'hF) begin bad++; $display("FAIL bp_q[%0d]: got %h want f", k, dut_if.q); end
      if (dut_if.r !== 15'h1) begin bad++; $display("FAIL bp_r[%0d]: got %h want 1", k, dut_if.r); end
      if (dut_if.in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready[%0d]: got %b want 0", k, dut_if.in_ready); end
      dut_if.in_valid = (k % 2 == 0);
      dut_if.a        = 31'h5;
      dut_if.b        = 16'h0;
      @(negedge clk);
    end
    dut_if.in_valid = 1'b0;
    ack();
    total += 4;
    if (dut_if.out_valid !== 1'b0) begin bad++; $display("FAIL bp_release_valid: got %b want 0", dut_if.out_valid); end
    if (dut_if.in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready: got %b want 1", dut_if.in_ready); end
    if (dut_if.q !== 31'hF) begin bad++; $display("FAIL bp_hold_q: got %h want f", dut_if.q); end
    if (dut_if.r !== 15'h1) begin bad++; $display("FAIL bp_hold_r: got %h want 1", dut_if.r); end
    @(negedge clk);
    total++;
    if (dut_if.in_ready !== 1'b1) begin bad++; $display("FAIL bp_no_spurious_op: in_ready=%b want 1", dut_if.in_ready); end
    $display("backpressure: held 5 cycles, released in_ready=%b", dut_if.in_ready);
  endtask

  task automatic test_reset_mid_run();
    int lat;
    start_op(31'h7FFF_FFFF, 16'h8000);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total += 5;
    if (dut_if.in_ready !== 1'b1) begin bad++; $display("FAIL midrst_in_ready: got %b want 1", dut_if.in_ready); end
    if (dut_if.out_valid !== 1'b0) begin bad++; $display("FAIL midrst_out_valid: got %b want 0", dut_if.out_valid); end
    if (dut_if.q !== 31'h0) begin bad++; $display("FAIL midrst_q: got %h want 0", dut_if.q); end
    if (dut_if.r !== 15'h0) begin bad++; $display("FAIL midrst_r: got %h want 0", dut_if.r); end
    if (dut_if.div_by_zero !== 1'b0) begin bad++; $display("FAIL midrst_dbz: got %b want 0", dut_if.div_by_zero); end
    start_op(31'h7, 16'h3);
    wait_valid(lat);
    total += 3;
    if (lat != LAT) begin bad++; $display("FAIL midrst_lat: got %0d want %0d", lat, LAT); end
    if (dut_if.q !== 31'h2) begin bad++; $display("FAIL midrst_q2: got %h want 2", dut_if.q); end
    if (dut_if.r !== 15'h1) begin bad++; $display("FAIL midrst_r2: got %h want 1", dut_if.r); end
    $display("reset mid-run, fresh op a=7 b=3 -> q=%h r=%h", dut_if.q, dut_if.r);
    ack();
  endtask

  task automatic test_random();
    int          lat;
    logic [30:0] av;
    logic [15:0] bv;
    logic [63:0] recon;
    for (int k = 0; k < 400; k++) begin
      av = 31'($urandom);
      bv = 16'($urandom) >> $urandom_range(0, 15);
      if (bv == 16'h0) bv = 16'h1;
      start_op(av, bv);
      wait_valid(lat);
      recon = clmul(dut_if.q, bv) ^ 64'(dut_if.r);
      total += 3;
      if (lat != LAT) begin bad++; $display("FAIL rand_lat[%0d]: got %0d want %0d", k, lat, LAT); end
      if (recon !== 64'(av)) begin
        bad++;
        $display("FAIL rand_identity[%0d]: a=%h b=%h q=%h r=%h gives %h want %h", k, av, bv, dut_if.q, dut_if.r, recon, 64'(av));
      end
      if (deg(64'(dut_if.r)) >= deg(64'(bv))) begin
        bad++;
        $display("FAIL rand_deg[%0d]: deg(r)=%0d want < deg(b)=%0d", k, deg(64'(dut_if.r)), deg(64'(bv)));
      end
      $display("rand %0d a=%h b=%h -> q=%h r=%h", k, av, bv, dut_if.q, dut_if.r);
      ack();
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_div_by_zero();
    test_back_pressure();
    test_reset_mid_run();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
